bike_light_ctrl: RTL and testbench

Mode controller and pattern sequencer for the bike light. Consumes the single-cycle `beat` strobe from beat32 as its time base. Turns a debounced push-button into a light mode (off / solid / flash / strobe). Drives the LED with the beat-sequenced pattern for the current mode.

---
 rtl/bike_light_ctrl_pkg.sv | 30 +++
 rtl/bike_light_ctrl_btn_sync.sv | 30 +++
 rtl/bike_light_ctrl.sv | 96 +++++++++
 tb/tb_bike_light_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bike_light_ctrl_pkg.sv
// Shared bike-light definitions: mode encodings, strobe phases, default frame width.
// Also used by beat32 and the display/top-level blocks.
package bike_light_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SOLID  = 2'd1,
    MODE_FLASH  = 2'd2,
    MODE_STROBE = 2'd3
  } mode_e;

  localparam int DEF_PHASE_W = 5;

  // Strobe lights on these four phases of each frame: a double blink.
  localparam int STROBE_PH0 = 0;
  localparam int STROBE_PH1 = 1;
  localparam int STROBE_PH2 = 4;
  localparam int STROBE_PH3 = 5;

  // Short presses cycle through the lit modes only; OFF is reached by long press.
  function automatic mode_e next_short(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_SOLID;
      MODE_SOLID: return MODE_FLASH;
      MODE_FLASH: return MODE_STROBE;
      default:    return MODE_SOLID;
    endcase
  endfunction

endpackage

// File: rtl/bike_light_ctrl_btn_sync.sv
// Two-flop synchronizer for the button plus a delay flop for edge detection.
// rise/fall are combinational from the synchronized level and its delayed copy.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      meta    <= din;
      level   <= meta;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/bike_light_ctrl.sv
// Bike light mode FSM (short press advances, long press forces OFF) and beat-driven
// LED pattern sequencer; led is registered one clk behind mode/phase.
module bike_light_ctrl
  import bike_light_ctrl_pkg::*;
#(
  parameter int PHASE_W          = DEF_PHASE_W,
  parameter int LONG_PRESS_BEATS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       beat,
  input  logic       btn,
  output logic       led,
  output logic [1:0] mode,
  output logic       mode_chg
);

  logic               btn_s;
  logic               rise;
  logic               fall;
  logic [7:0]         hold_cnt;
  logic               long_fired;
  logic               long_trig;
  logic [PHASE_W-1:0] phase;
  logic               led_d;
  mode_e              mode_q;
  mode_e              mode_d;

  btn_sync_edge u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .din   (btn),
    .level (btn_s),
    .rise  (rise),
    .fall  (fall)
  );

  // A rise restarts the hold count, so a beat landing on the rise is not counted.
  assign long_trig = btn_s && !long_fired && beat && !rise &&
                     (hold_cnt == 8'(LONG_PRESS_BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt   <= 8'd0;
      long_fired <= 1'b0;
    end else if (rise) begin
      hold_cnt   <= 8'd0;
      long_fired <= 1'b0;
    end else if (btn_s && !long_fired && beat) begin
      if (long_trig) long_fired <= 1'b1;
      else           hold_cnt   <= hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= MODE_OFF;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (long_trig)                mode_d = MODE_OFF;
    else if (fall && !long_fired) mode_d = next_short(mode_q);
  end

  // Phase restarts on a mode change so every pattern begins at the frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      mode_chg <= 1'b0;
    end else begin
      mode_chg <= (mode_d != mode_q);
      if (mode_d != mode_q) phase <= '0;
      else if (beat)        phase <= phase + PHASE_W'(1);
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_SOLID:  led_d = 1'b1;
      MODE_FLASH:  led_d = ~phase[PHASE_W-1];
      MODE_STROBE: led_d = (phase == PHASE_W'(STROBE_PH0)) || (phase == PHASE_W'(STROBE_PH1)) ||
                           (phase == PHASE_W'(STROBE_PH2)) || (phase == PHASE_W'(STROBE_PH3));
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= 1'b0;
    else       led <= led_d;
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_bike_light_ctrl.sv
// Directed bench for bike_light_ctrl: reset, short/long presses, FLASH/STROBE patterns,
// release timed onto a beat edge, and asynchronous reset mid-pattern.
module tb_bike_light_ctrl;
  import bike_light_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       beat;
  logic       btn;
  logic       led;
  logic [1:0] mode;
  logic       mode_chg;

  int n_chk  = 0;
  int n_fail = 0;
  int bph    = 0;

  always #5 clk = ~clk;

  bike_light_ctrl #(.PHASE_W(5), .LONG_PRESS_BEATS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .beat     (beat),
    .btn      (btn),
    .led      (led),
    .mode     (mode),
    .mode_chg (mode_chg)
  );

  // One-clk beat every 10 clks, changed on the falling edge.
  initial begin
    beat = 1'b0;
    forever begin
      @(negedge clk);
      bph++;
      beat = (bph % 10 == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int led_model(input int m, input int ph);
    case (m)
      1:       return 1;
      2:       return (ph < 16) ? 1 : 0;
      3:       return (ph == 0 || ph == 1 || ph == 4 || ph == 5) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Short press; mode must change exactly on the 3rd edge after release.
  task automatic press(input int exp_mode);
    int old;
    old = int'(mode);
    @(negedge clk) btn = 1'b1;
    repeat (30) @(negedge clk);
    btn = 1'b0;
    @(posedge clk); #1 chk("press_edge1_mode", mode, old);
    @(posedge clk); #1 chk("press_edge2_mode", mode, old);
    @(posedge clk); #1 chk("press_mode", mode, exp_mode);
    chk("press_chg", mode_chg, 1);
  endtask

  // Called right after a mode change: phase is 0, checks led every clk.
  task automatic run_pattern(input int m, input int nclk);
    int   ph;
    int   chg;
    int   exp;
    logic b;
    ph  = 0;
    chg = 0;
    for (int i = 0; i < nclk; i++) begin
      @(posedge clk);
      b   = beat;
      exp = led_model(m, ph);
      if (b) ph = (ph + 1) % 32;
      #1;
      chk($sformatf("led_m%0d_clk%0d", m, i), led, exp);
      if (mode_chg) chg++;
    end
    chk("pattern_chg_count", chg, 0);
    chk("pattern_mode", mode, m);
  endtask

  task automatic long_press(input int start_mode, input bit exp_chg);
    int   k;
    int   chg;
    logic b;
    k   = 0;
    chg = 0;
    @(negedge clk) btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    while (k < 20) begin
      @(posedge clk);
      b = beat;
      #1;
      if (b) begin
        k++;
        if (k == 15) chk("lp_mode_beat15", mode, start_mode);
        if (k == 16) begin
          chk("lp_mode_beat16", mode, 0);
          if (exp_chg) chk("lp_chg_beat16", mode_chg, 1);
        end
      end
      if (mode_chg && !(b && k == 16 && exp_chg)) chg++;
    end
    @(negedge clk) btn = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mode_chg) chg++;
    end
    chk("lp_extra_chg", chg, 0);
    chk("lp_final_mode", mode, 0);
  endtask

  // Release placed so the mode update lands on a beat edge.
  task automatic collide_press(input int exp_mode);
    @(negedge clk) btn = 1'b1;
    repeat (3) @(posedge clk);
    do @(posedge clk); while (beat !== 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk) btn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    chk("collide_mode", mode, exp_mode);
    chk("collide_chg", mode_chg, 1);
  endtask

  initial begin
    int chg;
    reset = 1'b1;
    btn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_led", led, 0);
    chk("rst_chg", mode_chg, 0);
    @(negedge clk) reset = 1'b0;

    chg = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (mode_chg) chg++;
    end
    chk("idle_chg_count", chg, 0);
    chk("idle_mode", mode, 0);
    chk("idle_led", led, 0);

    press(1);
    run_pattern(1, 20);
    press(2);
    run_pattern(2, 660);
    press(3);
    run_pattern(3, 660);
    press(1);
    run_pattern(1, 10);

    press(2);
    run_pattern(2, 20);
    long_press(2, 1'b1);
    long_press(0, 1'b0);

    press(1);
    run_pattern(1, 10);
    collide_press(2);
    run_pattern(2, 180);

    press(3);
    run_pattern(3, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_mode", mode, 0);
    chk("async_rst_chg", mode_chg, 0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_mode", mode, 0);
    chk("post_rst_led", led, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
